// File: rtl/oam_banked_memory.sv
// Banked sprite attribute memory: narrow single-bank write port, wide all-bank read port,
// and a clear engine that fills every entry with CLEAR_WORD in ENTRIES cycles.
module oam_banked_memory #(
  parameter int                 WORD_W     = 16,
  parameter int                 BANKS      = 2,
  parameter int                 ENTRIES    = 64,
  parameter logic [WORD_W-1:0]  CLEAR_WORD = 16'hFFFF,
  localparam int                RA_W       = $clog2(ENTRIES),
  localparam int                BS_W       = $clog2(BANKS),
  localparam int                WA_W       = RA_W + BS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WA_W-1:0]         write_addr,
  input  logic [WORD_W-1:0]       write_data,
  input  logic                    write_enable,
  output logic                    write_ready,
  input  logic                    clear_start,
  output logic                    busy,
  input  logic [RA_W-1:0]         read_addr,
  input  logic                    read_enable,
  output logic [BANKS*WORD_W-1:0] read_data,
  output logic                    read_valid
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;

  logic [0:0]        state;
  logic [RA_W-1:0]   counter;
  logic [WORD_W-1:0] mem [BANKS][ENTRIES];

  logic              clearing;
  logic [BANKS-1:0]  wr_bank;
  logic [RA_W-1:0]   wr_idx;
  logic [WORD_W-1:0] wr_word;

  assign busy        = (state == CLEARING);
  assign write_ready = (state == IDLE);

  // Clear sequencer: one entry per cycle across all banks, back to IDLE after the last entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEARING;
            counter <= '0;
          end
        end
        CLEARING: begin
          if (counter == RA_W'(ENTRIES - 1)) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  // Writes are gated by reset so an aborted clear leaves the current entry untouched
  always_comb begin
    clearing = (state == CLEARING) && !reset;
    wr_idx   = clearing ? counter : write_addr[WA_W-1:BS_W];
    wr_word  = clearing ? CLEAR_WORD : write_data;
    wr_bank  = '0;
    for (int b = 0; b < BANKS; b++) begin
      wr_bank[b] = clearing ||
                   (!reset && (state == IDLE) && write_enable &&
                    (write_addr[BS_W-1:0] == BS_W'(b)));
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (wr_bank[b]) begin
        mem[b][wr_idx] <= wr_word;
      end
    end
  end

  // Registered read; non-blocking update of mem makes same-edge collisions read-first
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) begin
        for (int b = 0; b < BANKS; b++) begin
          read_data[WORD_W*b +: WORD_W] <= mem[b][read_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_banked_memory.sv
// Directed bench for oam_banked_memory: table of single-cycle vectors plus
// hand-written sequences for the clear engine and reset-abort cases.
module tb_oam_banked_memory;

  logic        clk;
  logic        reset;
  logic [6:0]  write_addr;
  logic [15:0] write_data;
  logic        write_enable;
  logic        write_ready;
  logic        clear_start;
  logic        busy;
  logic [5:0]  read_addr;
  logic        read_enable;
  logic [31:0] read_data;
  logic        read_valid;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [5:0]  ra;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  oam_banked_memory dut (
    .clk          (clk),
    .reset        (reset),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_ready  (write_ready),
    .clear_start  (clear_start),
    .busy         (busy),
    .read_addr    (read_addr),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .read_valid   (read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    write_enable = v.we;
    write_addr   = v.wa;
    write_data   = v.wd;
    read_enable  = v.re;
    read_addr    = v.ra;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  initial begin
    int cnt;
    int ready_bad;
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    write_addr   = '0;
    write_data   = '0;
    write_enable = 1'b0;
    clear_start  = 1'b0;
    read_addr    = '0;
    read_enable  = 1'b0;

    // wa = {entry, bank}; data check expects {bank1, bank0}
    vecs[0]  = '{1'b1, 7'd0,   16'h1111, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 7'd1,   16'h2222, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 7'd0,   16'h0000, 1'b1, 6'd0,  1'b1, 1'b1, 32'h2222_1111};
    vecs[3]  = '{1'b1, 7'd126, 16'h0BAD, 1'b0, 6'd0,  1'b0, 1'b1, 32'h2222_1111};
    vecs[4]  = '{1'b1, 7'd127, 16'hABCD, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 7'd0,   16'h0000, 1'b1, 6'd63, 1'b1, 1'b1, 32'hABCD_0BAD};
    vecs[6]  = '{1'b0, 7'd0,   16'h0000, 1'b0, 6'd0,  1'b0, 1'b1, 32'hABCD_0BAD};
    vecs[7]  = '{1'b1, 7'd0,   16'h5555, 1'b1, 6'd0,  1'b1, 1'b1, 32'h2222_1111};
    vecs[8]  = '{1'b0, 7'd0,   16'h0000, 1'b1, 6'd0,  1'b1, 1'b1, 32'h2222_5555};
    vecs[9]  = '{1'b1, 7'd2,   16'h0102, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 7'd3,   16'h0304, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 7'd0,   16'h0000, 1'b1, 6'd1,  1'b1, 1'b1, 32'h0304_0102};

    step();
    step();
    checkOutput("reset_busy",        {31'd0, busy},        32'd0);
    checkOutput("reset_write_ready", {31'd0, write_ready}, 32'd1);
    checkOutput("reset_read_valid",  {31'd0, read_valid},  32'd0);
    checkOutput("reset_read_data",   read_data,            32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, read_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("vec%0d_data", i), read_data, vecs[i].exp_data);
      end
    end

    // Full clear with reads, a dropped write and a second start injected mid-clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    cnt       = 0;
    ready_bad = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (write_ready !== 1'b0) ready_bad++;
      read_enable = (cnt <= 3);
      read_addr   = (cnt == 2) ? 6'd1 : 6'd0;
      if (cnt == 10) begin
        write_enable = 1'b1;
        write_addr   = 7'd5;
        write_data   = 16'h1234;
        clear_start  = 1'b1;
      end
      step();
      write_enable = 1'b0;
      clear_start  = 1'b0;
      read_enable  = 1'b0;
      if (cnt == 1) checkOutput("clear_readfirst_e0", read_data, 32'h2222_5555);
      if (cnt == 2) checkOutput("clear_readfirst_e1", read_data, 32'h0304_0102);
      if (cnt == 3) checkOutput("clear_done_e0",      read_data, 32'hFFFF_FFFF);
    end
    checkOutput("busy_len",          cnt,                  32'd64);
    checkOutput("ready_low_in_clear", ready_bad,           32'd0);
    checkOutput("ready_after_clear", {31'd0, write_ready}, 32'd1);

    for (int e = 0; e < 64; e++) begin
      read_enable = 1'b1;
      read_addr   = 6'(e);
      step();
      checkOutput($sformatf("cleared_e%0d", e), read_data, 32'hFFFF_FFFF);
    end
    read_enable = 1'b0;

    // Fill known pattern, then abort a clear with reset after 10 entries
    for (int e = 0; e < 64; e++) begin
      applyStimulus('{1'b1, {6'(e), 1'b0}, 16'(e), 1'b0, 6'd0, 1'b0, 1'b0, 32'h0});
      applyStimulus('{1'b1, {6'(e), 1'b1}, 16'(e + 16'h100), 1'b0, 6'd0, 1'b0, 1'b0, 32'h0});
    end
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    reset       = 1'b1;
    read_enable = 1'b1;
    step();
    reset       = 1'b0;
    read_enable = 1'b0;
    checkOutput("abort_busy",        {31'd0, busy},        32'd0);
    checkOutput("abort_write_ready", {31'd0, write_ready}, 32'd1);
    checkOutput("abort_read_valid",  {31'd0, read_valid},  32'd0);
    checkOutput("abort_read_data",   read_data,            32'd0);
    for (int e = 0; e < 64; e++) begin
      read_enable = 1'b1;
      read_addr   = 6'(e);
      step();
      if (e < 10)
        checkOutput($sformatf("abort_e%0d", e), read_data, 32'hFFFF_FFFF);
      else
        checkOutput($sformatf("abort_e%0d", e), read_data, {16'(e + 16'h100), 16'(e)});
    end
    read_enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
